// File: rtl/alfa_sequenciador.sv
// Note-sequence controller for the Alfa_desc decoder: plays a programmable table of
// {tom, notas, duration} entries, one-shot or looping, with abort and live table writes.
module alfa_sequenciador #(
    parameter int DEPTH    = 16,
    parameter int DUR_W    = 8,
    parameter int PRESCALE = 1000,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_tom,
    input  logic [2:0]        wr_notas,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic              tom,
    output logic              notas1,
    output logic              notas2,
    output logic              notas3,
    output logic              note_vld,
    output logic [ADDR_W-1:0] step,
    output logic              busy,
    output logic              done
);

    localparam int                PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PRELOAD  = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, FINISH} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q,   ptr_d;
    logic [ADDR_W:0]     len_q,   len_d;
    logic [DUR_W-1:0]    dcnt_q,  dcnt_d;
    logic [PCNT_W-1:0]   pcnt_q,  pcnt_d;
    logic [3:0]          note_q,  note_d;
    logic                vld_q,   vld_d;
    logic [ADDR_W-1:0]   step_q,  step_d;
    logic                done_q,  done_d;

    logic [DUR_W+3:0]    mem_q [DEPTH];
    logic [DUR_W+3:0]    entry;
    logic [DUR_W-1:0]    entry_dur;
    logic                last_entry;

    // Table has no reset: contents are undefined until the host writes them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {wr_tom, wr_notas, wr_dur};
        end
    end

    assign entry      = mem_q[ptr_q];
    assign entry_dur  = entry[DUR_W-1:0];
    assign last_entry = ({1'b0, ptr_q} == (len_q - LEN_ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            len_q   <= '0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
            note_q  <= '0;
            vld_q   <= 1'b0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            dcnt_q  <= dcnt_d;
            pcnt_q  <= pcnt_d;
            note_q  <= note_d;
            vld_q   <= vld_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        dcnt_d  = dcnt_q;
        pcnt_d  = pcnt_q;
        note_d  = note_q;
        vld_d   = vld_q;
        step_d  = step_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            note_d  = '0;
            vld_d   = 1'b0;
            step_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (seq_len != '0)) begin
                        state_d = FETCH;
                        ptr_d   = '0;
                        len_d   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                    end
                end
                FETCH: begin
                    note_d  = entry[DUR_W+3:DUR_W];
                    step_d  = ptr_q;
                    vld_d   = 1'b1;
                    dcnt_d  = (entry_dur == '0) ? DUR_ONE : entry_dur;
                    pcnt_d  = PRELOAD;
                    state_d = PLAY;
                end
                PLAY: begin
                    // One tick = PRESCALE cycles; the note ends on the last cycle of its last tick.
                    if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - PCNT_ONE;
                    end else if (dcnt_q > DUR_ONE) begin
                        dcnt_d = dcnt_q - DUR_ONE;
                        pcnt_d = PRELOAD;
                    end else begin
                        dcnt_d = '0;
                        if (!last_entry) begin
                            ptr_d   = ptr_q + PTR_ONE;
                            state_d = FETCH;
                        end else if (loop) begin
                            ptr_d   = '0;
                            state_d = FETCH;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    note_d  = '0;
                    vld_d   = 1'b0;
                    step_d  = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign {tom, notas1, notas2, notas3} = note_q;
    assign note_vld = vld_q;
    assign step     = step_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_alfa_sequenciador.sv
// Bench for alfa_sequenciador: a note-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alfa_sequenciador;

    localparam int PRE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       wr_tom;
    logic [2:0] wr_notas;
    logic [7:0] wr_dur;
    logic [4:0] seq_len;
    logic       start;
    logic       stop;
    logic       loop;
    logic       tom, notas1, notas2, notas3, note_vld, busy, done;
    logic [3:0] step;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alfa_sequenciador #(.DEPTH(16), .DUR_W(8), .PRESCALE(PRE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_tom(wr_tom),
        .wr_notas(wr_notas), .wr_dur(wr_dur), .seq_len(seq_len), .start(start),
        .stop(stop), .loop(loop), .tom(tom), .notas1(notas1), .notas2(notas2),
        .notas3(notas3), .note_vld(note_vld), .step(step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: each note is visible for max(dur,1)*PRE+1 cycles; the successor
    // (and the loop decision) is chosen one cycle before the visible change.
    logic [3:0] tbl_note [16];
    int         tbl_dur  [16];
    logic       m_busy, m_done, m_vld;
    logic [3:0] m_step, m_note;
    int         m_remain, m_len, m_cur, m_nxt;
    bit         m_fin;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_vld = 0; m_step = 0; m_note = 0;
                m_fin = 0; m_remain = 0; m_cur = 0; m_nxt = 0; m_len = 0;
            end else begin
                if (stop) begin
                    m_busy = 0; m_done = 0; m_vld = 0; m_step = 0; m_note = 0;
                end else if (!m_busy) begin
                    m_done = 0;
                    if (start && seq_len != 0) begin
                        m_busy = 1; m_fin = 0; m_nxt = 0; m_remain = 1;
                        m_len = (seq_len > 16) ? 16 : int'(seq_len);
                    end
                end else begin
                    m_remain--;
                    if (m_remain == 0) begin
                        if (m_fin) begin
                            m_busy = 0; m_done = 1; m_vld = 0; m_step = 0; m_note = 0;
                        end else begin
                            m_cur = m_nxt;
                            m_note = tbl_note[m_cur];
                            m_step = 4'(m_cur);
                            m_vld = 1;
                            m_remain = ((tbl_dur[m_cur] == 0) ? 1 : tbl_dur[m_cur]) * PRE + 1;
                        end
                    end else if (m_remain == 1) begin
                        if (m_cur == m_len - 1) begin
                            if (loop) m_nxt = 0;
                            else m_fin = 1;
                        end else begin
                            m_nxt = m_cur + 1;
                        end
                    end
                end
                if (wr_en) begin
                    tbl_note[wr_addr] = {wr_tom, wr_notas};
                    tbl_dur[wr_addr] = int'(wr_dur);
                end
            end
        end
    end

    wire [10:0] dut_vec = {tom, notas1, notas2, notas3, note_vld, step, busy, done};
    wire [10:0] mdl_vec = {m_note, m_vld, m_step, m_busy, m_done};

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                tests++;
                if (dut_vec !== mdl_vec) begin
                    fails++;
                    $display("FAIL model_cmp t=%0t: dut {note,vld,step,busy,done}=%b model=%b",
                             $time, dut_vec, mdl_vec);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic t, input logic [2:0] n, input int d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(a); wr_tom = t; wr_notas = n; wr_dur = 8'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_for_step(input int s, input int bound);
        int n = 0;
        while (!(note_vld && step == 4'(s)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_step", 32'(n < bound), 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", 32'(n < bound), 32'd1);
    endtask

    task automatic base_table();
        wr(0, 1'b0, 3'b000, 1);
        wr(1, 1'b0, 3'b101, 2);
        wr(2, 1'b1, 3'b111, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, maxs, h3;
        rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_tom = 0; wr_notas = 0; wr_dur = 0;
        seq_len = 0; start = 0; stop = 0; loop = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_outputs", 32'(dut_vec), 32'd0);

        // One-shot playback with literal timeline
        base_table();
        seq_len = 5'd3; loop = 1'b0;
        pulse_start();
        check("start_busy", 32'({busy, note_vld}), 32'b10);
        @(negedge clk);
        check("note0", 32'({tom, notas1, notas2, notas3, note_vld, step}), 32'b0000_1_0000);
        repeat (3) @(negedge clk);
        check("note1", 32'({tom, notas1, notas2, notas3, note_vld, step}), 32'b0101_1_0001);
        repeat (5) @(negedge clk);
        check("note2", 32'({tom, notas1, notas2, notas3, note_vld, step}), 32'b1111_1_0010);
        repeat (6) @(negedge clk);
        check("note2_end", 32'({tom, notas1, notas2, notas3, busy, done}), 32'b1111_1_0);
        @(negedge clk);
        check("done_pulse", 32'({dut_vec}), 32'b0000_0_0000_0_1);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);

        // Asynchronous reset mid-play
        pulse_start();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Looping playback, then drop loop during entry 1
        loop = 1'b1;
        pulse_start();
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("loop_no_done", 32'(cnt), 32'd0);
        wait_for_step(1, 20);
        loop = 1'b0;
        wait_done(40);

        // Abort during entry 1; start and stop together in IDLE
        @(negedge clk);
        pulse_start();
        wait_for_step(1, 20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_clear", 32'(dut_vec), 32'd0);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);

        // seq_len 0 ignored; seq_len 20 clamps to 16; duration 0 plays as 1
        seq_len = 5'd0;
        pulse_start();
        check("len0_ignored", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            wr(i, 1'($urandom), 3'($urandom), (i == 3) ? 0 : int'($urandom_range(1, 3)));
        end
        seq_len = 5'd20;
        pulse_start();
        cnt = 0; maxs = 0; h3 = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (note_vld) begin
                if (int'(step) > maxs) maxs = int'(step);
                if (step == 4'd3) h3++;
            end
        end
        check("len20_done", 32'(cnt < 200), 32'd1);
        check("len20_last_step", 32'(maxs), 32'd15);
        check("dur0_hold", 32'(h3), 32'd3);

        // Rewrite an entry while an earlier one is playing
        base_table();
        seq_len = 5'd3;
        pulse_start();
        wait_for_step(1, 20);
        wr(2, 1'b0, 3'b011, 2);
        wait_for_step(2, 20);
        check("live_write", 32'({tom, notas1, notas2, notas3}), 32'b0011);
        wait_done(20);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 300) begin
                wr_en = 1'b0; start = 1'b0; stop = 1'b0;
                #2 rst_n = 1'b0;
                #1 check("rand_reset", 32'({busy, note_vld, done}), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                wr_en    = ($urandom_range(0, 3) == 0);
                wr_addr  = 4'($urandom);
                wr_tom   = 1'($urandom);
                wr_notas = 3'($urandom);
                wr_dur   = 8'($urandom_range(0, 3));
                start    = ($urandom_range(0, 7) == 0);
                stop     = ($urandom_range(0, 59) == 0);
                seq_len  = 5'($urandom_range(0, 20));
                if ($urandom_range(0, 29) == 0) loop = ~loop;
            end
        end
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
